retrigger_ctrl: RTL and testbench

Synchronous per-channel retrigger controller for the trigger front end. Each of WIDTH discriminator inputs is synchronised and edge-detected. Each accepted edge produces an active-low output pulse of programmable length, followed by a programmable dead time during which further edges are vetoed. Pulse length, dead time and the per-channel activity mask are set through a small write-only configuration port. The block sits between the discriminator inputs and the coincidence/trigger logic.

---
 rtl/retrigger_pkg.sv | 19 +
 rtl/retrig_chan.sv | 111 +++++++++++
 rtl/retrigger_ctrl.sv | 90 +++++++++
 tb/tb_retrigger_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/retrigger_pkg.sv
// Shared types and constants for the retrigger controller: channel FSM states,
// configuration register map and power-on register values.
package retrigger_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        DEAD  = 2'd2
    } chan_state_t;

    localparam logic [1:0] ADDR_MASK_LO   = 2'd0;
    localparam logic [1:0] ADDR_MASK_HI   = 2'd1;
    localparam logic [1:0] ADDR_PULSE_LEN = 2'd2;
    localparam logic [1:0] ADDR_DEAD_LEN  = 2'd3;

    localparam int RST_PULSE_LEN = 1;
    localparam int RST_DEAD_LEN  = 0;

endpackage

// File: rtl/retrig_chan.sv
// One retrigger channel: input synchroniser, rising-edge detect, and the
// IDLE/PULSE/DEAD state machine producing an active-low pulse plus dead time.
module retrig_chan
    import retrigger_pkg::*;
#(
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pulse_in,
    input  logic            act,
    input  logic [CNTW-1:0] pulse_len,
    input  logic [CNTW-1:0] dead_len,
    output logic            q,
    output logic            busy,
    output logic            veto
);

    logic            sync1;
    logic            sync2;
    logic            sync3;
    logic            rise;
    chan_state_t     state;
    chan_state_t     state_nxt;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_nxt;

    // NOTE: non-blocking assignments let each flop sample the previous stage's
    // old value, which is what turns three statements into a three-deep chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= pulse_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        veto      = 1'b0;
        case (state)
            IDLE: begin
                if (rise && act) begin
                    state_nxt = PULSE;
                    cnt_nxt   = (pulse_len == '0) ? '0 : pulse_len - 1'b1;
                end
            end
            PULSE: begin
                veto = rise;
                if (!act) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (dead_len == '0) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = DEAD;
                    cnt_nxt   = dead_len - 1'b1;
                end
            end
            DEAD: begin
                veto = rise;
                if (!act) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs lag the state by one flop; gating with act releases a masked
    // channel on the same edge its FSM is forced back to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q    <= 1'b1;
            busy <= 1'b0;
        end else begin
            q    <= !((state == PULSE) && act);
            busy <= (state != IDLE) && act;
        end
    end

endmodule

// File: rtl/retrigger_ctrl.sv
// Retrigger controller top: configuration registers, write acknowledge and
// WIDTH channel instances. Define RETRIG_VETO_CNT_EN to build the veto counter.
module retrigger_ctrl
    import retrigger_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pulse_in,
    input  logic             cfg_wr,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic             cfg_ack,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] busy,
    output logic [15:0]      veto_cnt
);

    logic [WIDTH-1:0] act_mask;
    logic [WIDTH-1:0] mask_nxt;
    logic [CNTW-1:0]  pulse_len;
    logic [CNTW-1:0]  dead_len;
    logic [WIDTH-1:0] veto;

    // Mask bit i lives in word i/32 at bit position i%32.
    always_comb begin
        mask_nxt = act_mask;
        for (int i = 0; i < WIDTH; i++) begin
            if (cfg_addr == ADDR_MASK_LO && i < 32) mask_nxt[i] = cfg_wdata[i % 32];
            if (cfg_addr == ADDR_MASK_HI && i >= 32) mask_nxt[i] = cfg_wdata[i % 32];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_mask  <= '1;
            pulse_len <= CNTW'(RST_PULSE_LEN);
            dead_len  <= CNTW'(RST_DEAD_LEN);
            cfg_ack   <= 1'b0;
        end else begin
            cfg_ack <= cfg_wr;
            if (cfg_wr) begin
                act_mask <= mask_nxt;
                case (cfg_addr)
                    ADDR_PULSE_LEN: pulse_len <= cfg_wdata[CNTW-1:0];
                    ADDR_DEAD_LEN:  dead_len  <= cfg_wdata[CNTW-1:0];
                    default: ;
                endcase
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        retrig_chan #(
            .CNTW(CNTW)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .pulse_in (pulse_in[i]),
            .act      (act_mask[i]),
            .pulse_len(pulse_len),
            .dead_len (dead_len),
            .q        (q[i]),
            .busy     (busy[i]),
            .veto     (veto[i])
        );
    end

`ifdef RETRIG_VETO_CNT_EN
    localparam logic [15:0] VETO_CNT_MAX = 16'hFFFF;

    // Counts cycles with any vetoed edge; a dead-time write wins over a veto.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            veto_cnt <= '0;
        end else if (cfg_wr && cfg_addr == ADDR_DEAD_LEN) begin
            veto_cnt <= '0;
        end else if ((|veto) && veto_cnt != VETO_CNT_MAX) begin
            veto_cnt <= veto_cnt + 16'd1;
        end
    end
`else
    logic veto_unused;
    assign veto_unused = |veto;
    assign veto_cnt    = '0;
`endif

endmodule

// File: tb/tb_retrigger_ctrl.sv
// Directed bench for retrigger_ctrl: a per-cycle vector table plus hand-written
// saturation and asynchronous-reset sequences.
module tb_retrigger_ctrl;
    import retrigger_pkg::*;

    localparam int WIDTH = 48;
    localparam int CNTW  = 8;
    localparam logic [WIDTH-1:0] ALL = '1;
    localparam logic [WIDTH-1:0] NONE = '0;
`ifdef RETRIG_VETO_CNT_EN
    localparam logic [15:0] V1   = 16'd1;
    localparam logic [15:0] VSAT = 16'hFFFF;
`else
    localparam logic [15:0] V1   = 16'd0;
    localparam logic [15:0] VSAT = 16'd0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] pulse_in;
    logic             cfg_wr;
    logic [1:0]       cfg_addr;
    logic [31:0]      cfg_wdata;
    logic             cfg_ack;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] busy;
    logic [15:0]      veto_cnt;

    always #5 clk = ~clk;

    retrigger_ctrl #(
        .WIDTH(WIDTH),
        .CNTW (CNTW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pulse_in (pulse_in),
        .cfg_wr   (cfg_wr),
        .cfg_addr (cfg_addr),
        .cfg_wdata(cfg_wdata),
        .cfg_ack  (cfg_ack),
        .q        (q),
        .busy     (busy),
        .veto_cnt (veto_cnt)
    );

    typedef struct {
        logic [WIDTH-1:0] pin;
        logic             wr;
        logic [1:0]       addr;
        logic [31:0]      wdata;
        logic [WIDTH-1:0] exp_q;
        logic [WIDTH-1:0] exp_busy;
        logic [15:0]      exp_veto;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [WIDTH-1:0] ch(input int i);
        logic [WIDTH-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic void add_wr(input logic [WIDTH-1:0] pin, input logic wr, input logic [1:0] addr,
                                   input logic [31:0] wdata, input logic [WIDTH-1:0] eq,
                                   input logic [WIDTH-1:0] eb, input logic [15:0] ev);
        vec_t v;
        v.pin      = pin;
        v.wr       = wr;
        v.addr     = addr;
        v.wdata    = wdata;
        v.exp_q    = eq;
        v.exp_busy = eb;
        v.exp_veto = ev;
        vecs.push_back(v);
    endfunction

    function automatic void add_n(input int n, input logic [WIDTH-1:0] pin, input logic [WIDTH-1:0] eq,
                                  input logic [WIDTH-1:0] eb, input logic [15:0] ev);
        for (int i = 0; i < n; i++) add_wr(pin, 1'b0, 2'd0, 32'd0, eq, eb, ev);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d, input string name,
                             input logic [15:0] exp_veto);
        cfg_wr    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        step();
        check({name, " ack"}, 64'(cfg_ack), 64'(1'b1));
        check({name, " veto_cnt"}, 64'(veto_cnt), 64'(exp_veto));
        cfg_wr = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] b0, b2, b3, b5, b7, b47;
        b0  = ch(0);
        b2  = ch(2);
        b3  = ch(3);
        b5  = ch(5);
        b7  = ch(7);
        b47 = ch(47);

        // Defaults (pulse_len=1, dead_len=0): channel 5 low for one cycle.
        add_n(3, b5, ALL, NONE, 16'd0);
        add_n(1, b5, ~b5, b5, 16'd0);
        add_n(1, b5, ALL, NONE, 16'd0);
        add_n(2, NONE, ALL, NONE, 16'd0);
        // pulse_len=4, dead_len=6; second rise 5 cycles later is vetoed.
        add_wr(NONE, 1'b1, ADDR_PULSE_LEN, 32'd4, ALL, NONE, 16'd0);
        add_wr(NONE, 1'b1, ADDR_DEAD_LEN, 32'd6, ALL, NONE, 16'd0);
        add_n(3, b0, ALL, NONE, 16'd0);
        add_n(2, NONE, ~b0, b0, 16'd0);
        add_n(2, b0, ~b0, b0, 16'd0);
        add_n(6, b0, ALL, b0, V1);
        add_n(2, b0, ALL, NONE, V1);
        add_n(3, NONE, ALL, NONE, V1);
        // Masked channel 7 ignores its rise and is not counted.
        add_wr(NONE, 1'b1, ADDR_MASK_LO, 32'hFFFF_FF7F, ALL, NONE, V1);
        add_n(5, b7, ALL, NONE, V1);
        add_n(3, NONE, ALL, NONE, V1);
        // pulse_len=10; mask bit 2 cleared mid-pulse releases the channel.
        add_wr(NONE, 1'b1, ADDR_MASK_LO, 32'hFFFF_FFFF, ALL, NONE, V1);
        add_wr(NONE, 1'b1, ADDR_PULSE_LEN, 32'd10, ALL, NONE, V1);
        add_n(3, b2, ALL, NONE, V1);
        add_n(2, b2, ~b2, b2, V1);
        add_wr(b2, 1'b1, ADDR_MASK_LO, 32'hFFFF_FFFB, ~b2, b2, V1);
        add_n(3, b2, ALL, NONE, V1);
        add_wr(b2, 1'b1, ADDR_MASK_LO, 32'hFFFF_FFFF, ALL, NONE, V1);
        add_n(3, NONE, ALL, NONE, V1);
        // pulse_len=0, dead_len=0: channels 0 and 47 together, then ch0 again 2 cycles on.
        add_wr(NONE, 1'b1, ADDR_PULSE_LEN, 32'd0, ALL, NONE, V1);
        add_wr(NONE, 1'b1, ADDR_DEAD_LEN, 32'd0, ALL, NONE, 16'd0);
        add_n(1, b0 | b47, ALL, NONE, 16'd0);
        add_n(1, b47, ALL, NONE, 16'd0);
        add_n(1, b0 | b47, ALL, NONE, 16'd0);
        add_n(1, b0 | b47, ~(b0 | b47), b0 | b47, 16'd0);
        add_n(1, b0 | b47, ALL, NONE, 16'd0);
        add_n(1, b0 | b47, ~b0, b0, 16'd0);
        add_n(2, b0 | b47, ALL, NONE, 16'd0);
        add_n(3, NONE, ALL, NONE, 16'd0);

        reset     = 1'b1;
        pulse_in  = '0;
        cfg_wr    = 1'b0;
        cfg_addr  = 2'd0;
        cfg_wdata = 32'd0;
        repeat (2) step();
        check("reset q", 64'(q), 64'(ALL));
        check("reset busy", 64'(busy), 64'(NONE));
        check("reset ack", 64'(cfg_ack), 64'(1'b0));
        check("reset veto_cnt", 64'(veto_cnt), 64'(16'd0));
        reset = 1'b0;

        foreach (vecs[i]) begin
            pulse_in  = vecs[i].pin;
            cfg_wr    = vecs[i].wr;
            cfg_addr  = vecs[i].addr;
            cfg_wdata = vecs[i].wdata;
            step();
            check($sformatf("vec%0d q", i), 64'(q), 64'(vecs[i].exp_q));
            check($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].exp_busy));
            check($sformatf("vec%0d ack", i), 64'(cfg_ack), 64'(vecs[i].wr));
            check($sformatf("vec%0d veto_cnt", i), 64'(veto_cnt), 64'(vecs[i].exp_veto));
        end
        cfg_wr   = 1'b0;
        pulse_in = '0;

        // Long lengths keep channels 0 and 1 busy while they toggle in opposite phase.
        cfg_write(ADDR_PULSE_LEN, 32'd255, "sat pulse_len", 16'd0);
        cfg_write(ADDR_DEAD_LEN, 32'd255, "sat dead_len", 16'd0);
        for (int i = 0; i < 70000; i++) begin
            pulse_in    = '0;
            pulse_in[0] = i[0];
            pulse_in[1] = ~i[0];
            step();
        end
        pulse_in = '0;
        repeat (4) step();
        check("veto_cnt saturated", 64'(veto_cnt), 64'(VSAT));
        step();
        check("veto_cnt holds", 64'(veto_cnt), 64'(VSAT));
        cfg_write(ADDR_DEAD_LEN, 32'd0, "veto clear", 16'd0);
        step();
        check("ack one cycle", 64'(cfg_ack), 64'(1'b0));
        check("veto_cnt stays clear", 64'(veto_cnt), 64'(16'd0));

        // Asynchronous reset in the middle of a channel 3 pulse.
        cfg_write(ADDR_PULSE_LEN, 32'd20, "arst pulse_len", 16'd0);
        pulse_in = b3;
        repeat (4) step();
        check("pre-reset q3", 64'(q[3]), 64'(1'b0));
        check("pre-reset busy3", 64'(busy[3]), 64'(1'b1));
        #2;
        reset = 1'b1;
        #1;
        check("async reset q", 64'(q), 64'(ALL));
        check("async reset busy", 64'(busy), 64'(NONE));
        step();
        reset    = 1'b0;
        pulse_in = '0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
